dmem_stage: RTL and testbench

DMEM_STAGE -- requirements
Module: dmem_stage

---
 rtl/rv32i_types.sv | 42 ++++
 rtl/load_align.sv | 35 +++
 rtl/dmem_stage.sv | 123 ++++++++++++
 tb/tb_dmem_stage.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared RV32I/RV64I opcode, funct3, access-size and dmem stage state types.
package rv32i_types;

  typedef enum logic [6:0] {
    op_load  = 7'b0000011,
    op_imm   = 7'b0010011,
    op_store = 7'b0100011,
    op_reg   = 7'b0110011
  } rv32i_opcode_t;

  typedef enum logic [2:0] {
    f3_lb  = 3'b000,
    f3_lh  = 3'b001,
    f3_lw  = 3'b010,
    f3_ld  = 3'b011,
    f3_lbu = 3'b100,
    f3_lhu = 3'b101,
    f3_lwu = 3'b110
  } load_funct3_t;

  typedef enum logic [2:0] {
    f3_sb = 3'b000,
    f3_sh = 3'b001,
    f3_sw = 3'b010,
    f3_sd = 3'b011
  } store_funct3_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    DONE = 2'b10
  } dmem_state_t;

  // funct3[1:0] encodes log2 of the access size in bytes
  typedef enum logic [1:0] {
    size_byte  = 2'b00,
    size_half  = 2'b01,
    size_word  = 2'b10,
    size_dword = 2'b11
  } access_size_t;

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - moves the addressed lane(s) of a cache word down to bit 0 and sign/zero-extends.
module load_align
  import rv32i_types::*;
#(
  parameter int DATA_W = 32,
  parameter int OFS_W  = 2
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [OFS_W-1:0]  offset,
  input  logic [2:0]        funct3,
  output logic [DATA_W-1:0] result
);

  logic [DATA_W-1:0] shifted;
  logic              sign;
  int                nbits;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    nbits   = 8 << funct3[1:0];
    sign    = 1'b0;
    unique case (access_size_t'(funct3[1:0]))
      size_byte: sign = shifted[7];
      size_half: sign = shifted[15];
      size_word: sign = shifted[31];
      default:   sign = shifted[DATA_W-1];
    endcase
    // funct3[2] selects the unsigned load variants
    sign = sign & ~funct3[2];
    for (int i = 0; i < DATA_W; i++) begin
      result[i] = (i < nbits) ? shifted[i] : sign;
    end
  end

endmodule

// File: rtl/dmem_stage.sv
// rtl/dmem_stage.sv - pipeline memory stage: issues one cache load/store per instruction and aligns the result.
module dmem_stage
  import rv32i_types::*;
#(
  parameter int DATA_W = 32,
  parameter int LANES  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_opcode,
  input  logic [2:0]        in_funct3,
  input  logic [DATA_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_rdata,
  output logic [LANES-1:0]  out_rmask,
  output logic [LANES-1:0]  out_wmask,
  output logic              out_misaligned,
  output logic              dmem_read,
  output logic              dmem_write,
  output logic [DATA_W-1:0] dmem_address,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic [LANES-1:0]  dmem_byte_enable,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_resp
);

  localparam int OFS_W = $clog2(LANES);

  dmem_state_t       state, next_state;
  logic [6:0]        opcode_q;
  logic [2:0]        funct3_q;
  logic [DATA_W-1:0] addr_q, wdata_q, rdata_q, load_result;
  logic [OFS_W-1:0]  offset;
  logic [LANES-1:0]  size_mask;
  logic              is_load, is_store, fault;

  // Illegal funct3 encodings are reported through the same fault flag as misalignment
  function automatic logic access_fault(input logic [6:0] op, input logic [2:0] f3,
                                        input logic [OFS_W-1:0] ofs);
    logic [OFS_W-1:0] align_bits;
    logic             illegal;
    align_bits = OFS_W'((1 << f3[1:0]) - 1);
    illegal    = 1'b0;
    if (op == op_load)
      illegal = (f3 == 3'b111) || (DATA_W == 32 && f3[1:0] == 2'b11);
    else if (op == op_store)
      illegal = f3[2] || (DATA_W == 32 && f3[1:0] == 2'b11);
    return (op == op_load || op == op_store) && (illegal || ((ofs & align_bits) != '0));
  endfunction

  assign offset   = addr_q[OFS_W-1:0];
  assign is_load  = (opcode_q == op_load);
  assign is_store = (opcode_q == op_store);
  assign fault    = access_fault(opcode_q, funct3_q, offset);

  always_comb begin
    size_mask = '0;
    for (int i = 0; i < LANES; i++) begin
      size_mask[i] = (i < (1 << funct3_q[1:0]));
    end
    size_mask = size_mask << offset;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (in_valid) begin
        next_state = ((in_opcode == op_load || in_opcode == op_store) &&
                      !access_fault(in_opcode, in_funct3, in_addr[OFS_W-1:0])) ? REQ : DONE;
      end
      REQ:     if (dmem_resp) next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opcode_q <= '0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else if (state == IDLE && in_valid) begin
      opcode_q <= in_opcode;
      funct3_q <= in_funct3;
      addr_q   <= in_addr;
      wdata_q  <= in_wdata;
      rdata_q  <= '0;
    end else if (state == REQ && dmem_resp && is_load) begin
      rdata_q <= load_result;
    end
  end

  load_align #(.DATA_W(DATA_W), .OFS_W(OFS_W)) u_load_align (
    .rdata  (dmem_rdata),
    .offset (offset),
    .funct3 (funct3_q),
    .result (load_result)
  );

  assign in_ready         = (state == IDLE);
  assign out_valid        = (state == DONE);
  assign out_rdata        = rdata_q;
  assign out_misaligned   = fault;
  assign out_rmask        = (is_load && !fault) ? size_mask : '0;
  assign out_wmask        = (is_store && !fault) ? size_mask : '0;
  assign dmem_read        = (state == REQ) && is_load;
  assign dmem_write       = (state == REQ) && is_store;
  assign dmem_address     = {addr_q[DATA_W-1:OFS_W], {OFS_W{1'b0}}};
  assign dmem_wdata       = dmem_write ? (wdata_q << {offset, 3'b000}) : '0;
  assign dmem_byte_enable = dmem_write ? size_mask : '0;

endmodule

// File: tb/tb_dmem_stage.sv
// tb/tb_dmem_stage.sv - scoreboard bench for dmem_stage at DATA_W=32 and DATA_W=64.
module tb_dmem_stage;

  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;
  localparam logic [6:0] RR = 7'b0110011;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, out_valid, out_ready, out_misaligned;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr, in_wdata, out_rdata, dmem_address, dmem_wdata, dmem_rdata;
  logic [3:0]  out_rmask, out_wmask, dmem_byte_enable;
  logic        dmem_read, dmem_write, dmem_resp;

  logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_out_misaligned;
  logic [6:0]  w_in_opcode;
  logic [2:0]  w_in_funct3;
  logic [63:0] w_in_addr, w_in_wdata, w_out_rdata, w_dmem_address, w_dmem_wdata, w_dmem_rdata;
  logic [7:0]  w_out_rmask, w_out_wmask, w_dmem_byte_enable;
  logic        w_dmem_read, w_dmem_write, w_dmem_resp;

  dmem_stage #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
    .out_rmask(out_rmask), .out_wmask(out_wmask), .out_misaligned(out_misaligned),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_address(dmem_address),
    .dmem_wdata(dmem_wdata), .dmem_byte_enable(dmem_byte_enable),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp)
  );

  dmem_stage #(.DATA_W(64)) dut64 (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_opcode(w_in_opcode), .in_funct3(w_in_funct3), .in_addr(w_in_addr), .in_wdata(w_in_wdata),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_rdata(w_out_rdata),
    .out_rmask(w_out_rmask), .out_wmask(w_out_wmask), .out_misaligned(w_out_misaligned),
    .dmem_read(w_dmem_read), .dmem_write(w_dmem_write), .dmem_address(w_dmem_address),
    .dmem_wdata(w_dmem_wdata), .dmem_byte_enable(w_dmem_byte_enable),
    .dmem_rdata(w_dmem_rdata), .dmem_resp(w_dmem_resp)
  );

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, rdata;
    int          dly;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_be;
    logic [31:0] e_rd;
    logic [3:0]  e_rmask, e_wmask;
    logic        e_mis;
  } vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   overlap  = 0;
  vec_t exp_q[$];
  vec_t vecs[$];
  vec_t mon_e;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata, input int dly,
                              input logic [31:0] e_addr, input logic [31:0] e_wdata,
                              input logic [3:0] e_be, input logic [31:0] e_rd,
                              input logic [3:0] e_rmask, input logic [3:0] e_wmask, input logic e_mis);
    vec_t v;
    v.op = op; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.dly = dly;
    v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_be = e_be; v.e_rd = e_rd;
    v.e_rmask = e_rmask; v.e_wmask = e_wmask; v.e_mis = e_mis;
    return v;
  endfunction

  // Scoreboard side: every 32-bit result handshake is matched against the oldest expectation
  always @(negedge clk) begin
    if (dmem_read && dmem_write) overlap++;
    if (w_dmem_read && w_dmem_write) overlap++;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_unexpected_out_valid", out_valid, 1'b0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("sb_out_rdata", out_rdata, mon_e.e_rd);
        check_eq("sb_out_rmask", out_rmask, mon_e.e_rmask);
        check_eq("sb_out_wmask", out_wmask, mon_e.e_wmask);
        check_eq("sb_out_misaligned", out_misaligned, mon_e.e_mis);
      end
    end
  end

  task automatic run_vec(input vec_t v);
    bit rd_exp, wr_exp;
    rd_exp = (v.e_rmask != 4'd0);
    wr_exp = (v.e_wmask != 4'd0);
    @(negedge clk);
    in_opcode = v.op; in_funct3 = v.f3; in_addr = v.addr; in_wdata = v.wdata;
    dmem_rdata = v.rdata; in_valid = 1'b1;
    check_eq("in_ready_before_accept", in_ready, 1'b1);
    exp_q.push_back(v);
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("dmem_read", dmem_read, rd_exp);
    check_eq("dmem_write", dmem_write, wr_exp);
    if (rd_exp || wr_exp) begin
      check_eq("early_out_valid", out_valid, 1'b0);
      check_eq("dmem_address", dmem_address, v.e_addr);
      check_eq("dmem_wdata", dmem_wdata, v.e_wdata);
      check_eq("dmem_byte_enable", dmem_byte_enable, v.e_be);
      repeat (v.dly) @(negedge clk);
      check_eq("req_held", {dmem_read, dmem_write, dmem_address}, {rd_exp, wr_exp, v.e_addr});
      dmem_resp = 1'b1;
      @(negedge clk);
      dmem_resp = 1'b0;
      check_eq("req_dropped", dmem_read | dmem_write, 1'b0);
    end
    check_eq("out_valid_at_latency", out_valid, 1'b1);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 0; in_opcode = 0; in_funct3 = 0; in_addr = 0; in_wdata = 0;
    out_ready = 1; dmem_rdata = 0; dmem_resp = 0;
    w_in_valid = 0; w_in_opcode = 0; w_in_funct3 = 0; w_in_addr = 0; w_in_wdata = 0;
    w_out_ready = 1; w_dmem_rdata = 0; w_dmem_resp = 0;
    repeat (2) @(negedge clk);
    check_eq("rst_in_ready", in_ready, 1'b1);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_dmem_rw", {dmem_read, dmem_write}, 2'b00);
    check_eq("rst_outputs", {out_rdata, out_rmask, out_wmask, out_misaligned}, '0);
    check_eq("rst_dmem_data", {dmem_address, dmem_wdata, dmem_byte_enable}, '0);
    check_eq("rst_w_in_ready", w_in_ready, 1'b1);
    rst = 1'b0;

    vecs.push_back(mk(LD, 3'b010, 32'h1000, 32'h0, 32'hDEADBEEF, 2, 32'h1000, 32'h0, 4'h0, 32'hDEADBEEF, 4'hF, 4'h0, 1'b0));
    vecs.push_back(mk(LD, 3'b000, 32'h1003, 32'h0, 32'h80FF0000, 0, 32'h1000, 32'h0, 4'h0, 32'hFFFFFF80, 4'h8, 4'h0, 1'b0));
    vecs.push_back(mk(LD, 3'b100, 32'h1003, 32'h0, 32'h80FF0000, 1, 32'h1000, 32'h0, 4'h0, 32'h00000080, 4'h8, 4'h0, 1'b0));
    vecs.push_back(mk(ST, 3'b001, 32'h2002, 32'h0000ABCD, 32'hFFFFFFFF, 1, 32'h2000, 32'hABCD0000, 4'hC, 32'h0, 4'h0, 4'hC, 1'b0));
    vecs.push_back(mk(LD, 3'b010, 32'h1001, 32'h0, 32'h12345678, 0, 32'h0, 32'h0, 4'h0, 32'h0, 4'h0, 4'h0, 1'b1));
    vecs.push_back(mk(LD, 3'b001, 32'h1002, 32'h0, 32'h80011234, 0, 32'h1000, 32'h0, 4'h0, 32'hFFFF8001, 4'hC, 4'h0, 1'b0));
    vecs.push_back(mk(LD, 3'b101, 32'h1000, 32'h0, 32'h80011234, 0, 32'h1000, 32'h0, 4'h0, 32'h00001234, 4'h3, 4'h0, 1'b0));
    vecs.push_back(mk(ST, 3'b000, 32'h0011, 32'h1234565A, 32'hFFFFFFFF, 0, 32'h0010, 32'h34565A00, 4'h2, 32'h0, 4'h0, 4'h2, 1'b0));
    vecs.push_back(mk(ST, 3'b010, 32'h0020, 32'hCAFEF00D, 32'h0, 3, 32'h0020, 32'hCAFEF00D, 4'hF, 32'h0, 4'h0, 4'hF, 1'b0));
    vecs.push_back(mk(RR, 3'b000, 32'h1234, 32'h5, 32'hFFFFFFFF, 0, 32'h0, 32'h0, 4'h0, 32'h0, 4'h0, 4'h0, 1'b0));
    vecs.push_back(mk(LD, 3'b111, 32'h1000, 32'h0, 32'hFFFFFFFF, 0, 32'h0, 32'h0, 4'h0, 32'h0, 4'h0, 4'h0, 1'b1));
    vecs.push_back(mk(ST, 3'b100, 32'h1000, 32'h1, 32'h0, 0, 32'h0, 32'h0, 4'h0, 32'h0, 4'h0, 4'h0, 1'b1));
    vecs.push_back(mk(LD, 3'b011, 32'h1000, 32'h0, 32'hFFFFFFFF, 0, 32'h0, 32'h0, 4'h0, 32'h0, 4'h0, 4'h0, 1'b1));
    vecs.push_back(mk(ST, 3'b001, 32'h2001, 32'h1, 32'h0, 0, 32'h0, 32'h0, 4'h0, 32'h0, 4'h0, 4'h0, 1'b1));
    vecs.push_back(mk(LD, 3'b110, 32'h1004, 32'h0, 32'h87654321, 1, 32'h1004, 32'h0, 4'h0, 32'h87654321, 4'hF, 4'h0, 1'b0));
    foreach (vecs[i]) run_vec(vecs[i]);

    // 64-bit ld with downstream back-pressure
    @(negedge clk);
    w_in_opcode = LD; w_in_funct3 = 3'b011; w_in_addr = 64'h8;
    w_dmem_rdata = 64'h0123456789ABCDEF; w_in_valid = 1'b1; w_out_ready = 1'b0;
    @(negedge clk);
    w_in_valid = 1'b0;
    check_eq("w_dmem_read", w_dmem_read, 1'b1);
    check_eq("w_dmem_address", w_dmem_address, 64'h8);
    w_dmem_resp = 1'b1;
    @(negedge clk);
    w_dmem_resp = 1'b0;
    w_dmem_rdata = 64'h0;
    check_eq("w_out_rmask", w_out_rmask, 8'hFF);
    for (int i = 0; i < 5; i++) begin
      check_eq("w_hold_valid", w_out_valid, 1'b1);
      check_eq("w_hold_rdata", w_out_rdata, 64'h0123456789ABCDEF);
      check_eq("w_hold_in_ready", w_in_ready, 1'b0);
      @(negedge clk);
    end
    w_out_ready = 1'b1;
    @(negedge clk);
    check_eq("w_release_in_ready", w_in_ready, 1'b1);
    check_eq("w_release_out_valid", w_out_valid, 1'b0);

    // Reset in the middle of an outstanding load, then a stale response
    @(negedge clk);
    in_opcode = LD; in_funct3 = 3'b010; in_addr = 32'h3000; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("midreq_read", dmem_read, 1'b1);
    #2 rst = 1'b1;
    #1;
    check_eq("midreq_rst_read_drop", dmem_read, 1'b0);
    check_eq("midreq_rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    dmem_rdata = 32'hBAD0BAD0;
    dmem_resp = 1'b1;
    @(negedge clk);
    dmem_resp = 1'b0;
    check_eq("stale_resp_out_valid", out_valid, 1'b0);
    check_eq("stale_resp_in_ready", in_ready, 1'b1);
    check_eq("stale_resp_rdata", out_rdata, 32'h0);
    @(negedge clk);
    check_eq("stale_resp_out_valid_later", out_valid, 1'b0);

    check_eq("rw_overlap", overlap, 0);
    check_eq("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
